// File: rtl/rv_div_pkg.sv
// rtl/rv_div_pkg.sv - shared types and helpers for the RV32M/RV64M iterative divider
package rv_div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_e;

   localparam int MAX_XLEN = 64;

   // Callers sign-extend narrower operands to MAX_XLEN first and keep the low XLEN bits.
   function automatic logic [MAX_XLEN-1:0] abs_val(input logic [MAX_XLEN-1:0] value,
                                                   input logic is_signed);
      return (is_signed && value[MAX_XLEN-1]) ? -value : value;
   endfunction

endpackage

// File: rtl/rv_div_step.sv
// rtl/rv_div_step.sv - one combinational restoring-division iteration
module rv_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   rem,
   input  logic            dividend_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_next,
   output logic            q_bit
);

   logic [XLEN+1:0] shifted;
   logic [XLEN+1:0] diff;

   // The extra top bit of diff acts as the borrow: set means the trial subtraction failed.
   always_comb begin
      shifted  = {rem, dividend_bit};
      diff     = shifted - {2'b00, divisor};
      q_bit    = ~diff[XLEN+1];
      rem_next = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
   end

endmodule

// File: rtl/rv_div_unit.sv
// rtl/rv_div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU
// Optional flush input enabled by defining RV_DIV_FLUSH_EN.
module rv_div_unit
   import rv_div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef RV_DIV_FLUSH_EN
   input  logic            flush,
`endif
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state;
   logic [CW-1:0]   cnt;
   logic [XLEN:0]   rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] dvsr;
   logic            q_neg;
   logic            r_neg;
   logic            sel_rem;
   logic            flush_req;

`ifdef RV_DIV_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   logic            is_signed;
   logic            sel_rem_in;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;

   always_comb begin
      is_signed  = (op == OP_DIV) || (op == OP_REM);
      sel_rem_in = (op == OP_REM) || (op == OP_REMU);
      div_zero   = (rs2 == '0);
      ovf        = is_signed && (rs1 == MIN_INT) && (&rs2);
      mag1       = XLEN'(abs_val(MAX_XLEN'($signed(rs1)), is_signed));
      mag2       = XLEN'(abs_val(MAX_XLEN'($signed(rs2)), is_signed));
   end

   logic [XLEN:0]   rem_next;
   logic            q_bit;
   logic [XLEN-1:0] q_next;
   logic [XLEN-1:0] fixed_q;
   logic [XLEN-1:0] fixed_r;

   rv_div_step #(.XLEN(XLEN)) u_step (
      .rem          (rem),
      .dividend_bit (quo[XLEN-1]),
      .divisor      (dvsr),
      .rem_next     (rem_next),
      .q_bit        (q_bit)
   );

   // quo doubles as the dividend shift register: dividend bits leave at the top,
   // quotient bits enter at the bottom.
   always_comb begin
      q_next  = {quo[XLEN-2:0], q_bit};
      fixed_q = q_neg ? -q_next : q_next;
      fixed_r = r_neg ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         sel_rem   <= 1'b0;
      end else if (flush_req) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sel_rem <= sel_rem_in;
                  q_neg   <= is_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                  r_neg   <= is_signed & rs1[XLEN-1];
                  quo     <= mag1;
                  dvsr    <= mag2;
                  rem     <= '0;
                  cnt     <= '0;
                  if (div_zero) begin
                     result    <= sel_rem_in ? rs1 : '1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else if (ovf) begin
                     result    <= sel_rem_in ? '0 : MIN_INT;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               quo <= q_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(XLEN - 1)) begin
                  result    <= sel_rem ? fixed_r : fixed_q;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_div_unit.sv
// tb/tb_rv_div_unit.sv - randomized self-checking bench for rv_div_unit against an arithmetic model
module tb_rv_div_unit;

   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        out_valid;
   logic        in_ready;
   logic        busy;
   logic [31:0] result;
`ifdef RV_DIV_FLUSH_EN
   logic        flush = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_div_unit #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef RV_DIV_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics expressed with native integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      case (o)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int bp, input string tag);
      logic [31:0] exp;
      logic [31:0] held;
      int          lat;
      logic        ok;
      exp = ref_result(o, a, b);
      @(negedge clk);
      check({tag, "/ready_pre"}, 64'(in_ready), 64'd1);
      op        = o;
      rs1       = a;
      rs2       = b;
      in_valid  = 1'b1;
      out_ready = (bp == 0);
      @(posedge clk);
      #1;
      in_valid = (bp > 0);
      rs1      = $urandom;
      rs2      = $urandom;
      op       = 2'($urandom);
      lat      = 1;
      ok       = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "/latency"}, 64'(lat), 64'(ref_latency(o, a, b)));
      check({tag, "/result"}, 64'(result), 64'(exp));
      check({tag, "/stall"}, 64'(ok), 64'd1);
      if (bp > 0) begin
         held = result;
         ok   = 1'b1;
         repeat (bp) begin
            @(negedge clk);
            if (result !== held || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1)
               ok = 1'b0;
         end
         check({tag, "/hold"}, 64'(ok), 64'd1);
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = 1'b0;
      end
      @(posedge clk);
      #1;
      check({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
      check({tag, "/idle"}, 64'({in_ready, busy}), 64'b10);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          rbp;
      logic        ok;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset/out_valid", 64'(out_valid), 64'd0);
      check("reset/result", 64'(result), 64'd0);
      check("reset/in_ready", 64'(in_ready), 64'd1);
      check("reset/busy", 64'(busy), 64'd0);
      rst_n = 1'b1;

      run_op(2'b01, 32'd100, 32'd7, 0, "divu_100_7");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "remu_f9_2");
      run_op(2'b01, 32'd5, 32'd0, 0, "divu_by0");
      run_op(2'b11, 32'd5, 32'd0, 0, "remu_by0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
      run_op(2'b01, 32'd9, 32'd3, 5, "divu_bp");

      // reset in the middle of an iteration sequence
      @(negedge clk);
      op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset/out_valid", 64'(out_valid), 64'd0);
      check("midreset/result", 64'(result), 64'd0);
      check("midreset/in_ready", 64'(in_ready), 64'd1);
      run_op(2'b01, 32'd20, 32'd4, 0, "after_reset");

`ifdef RV_DIV_FLUSH_EN
      @(negedge clk);
      op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_calc/in_ready", 64'(in_ready), 64'd1);
      ok = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      check("flush_calc/no_valid", 64'(ok), 64'd1);

      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op = 2'b01; rs1 = 32'd8; rs2 = 32'd0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush_accept/in_ready", 64'(in_ready), 64'd1);
      check("flush_accept/no_valid", 64'({out_valid, busy}), 64'd0);
      run_op(2'b11, 32'd17, 32'd5, 0, "after_flush");
`endif

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       ra = 32'h8000_0000;
            1:       ra = $urandom_range(0, 200);
            default: ra = $urandom;
         endcase
         rbp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_op(ro, ra, rb, rbp, $sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
